// File: rtl/z80_bus_bridge.sv
// Bridges async Z80 strobes into pxclk: writes are posted through a FIFO, reads drain the FIFO first.
// Writes reach the device SYN_LEN+1 cycles after cpu_wr rises; cpu_wait asserts when nearly full or while a read is pending.
module z80_bus_bridge #(
  parameter int ADDR_W     = 1,
  parameter int SYN_LEN    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pxclk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [7:0]                    cpu_din,
  input  logic                          cpu_wr,
  input  logic                          cpu_rd,
  output logic [7:0]                    cpu_dout,
  output logic                          cpu_wait,
  output logic                          dev_wr_valid,
  input  logic                          dev_wr_ready,
  output logic [ADDR_W-1:0]             dev_addr,
  output logic [7:0]                    dev_wdata,
  output logic                          dev_rd_req,
  input  logic                          dev_rd_ack,
  input  logic [7:0]                    dev_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_REQ} state_t;

  state_t              state, state_n;
  logic [SYN_LEN-1:0]  wr_sync, rd_sync;
  logic                wr_last, rd_last;
  logic                wr_tick, rd_tick;
  logic [ADDR_W+7:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                full, push, pop;
  logic [ADDR_W-1:0]   rd_addr;
  logic                err_set;

  // Chains reset to ones so a strobe already high at reset release is not seen as an edge.
  always_ff @(posedge pxclk) begin
    if (reset) begin
      wr_sync <= '1;
      rd_sync <= '1;
      wr_last <= 1'b1;
      rd_last <= 1'b1;
    end else begin
      wr_sync <= {wr_sync[SYN_LEN-2:0], cpu_wr};
      rd_sync <= {rd_sync[SYN_LEN-2:0], cpu_rd};
      wr_last <= wr_sync[SYN_LEN-1];
      rd_last <= rd_sync[SYN_LEN-1];
    end
  end

  assign wr_tick = wr_sync[SYN_LEN-1] & ~wr_last;
  assign rd_tick = rd_sync[SYN_LEN-1] & ~rd_last;

  assign full         = (fifo_level == LW'(FIFO_DEPTH));
  assign push         = wr_tick & ~full;
  assign dev_wr_valid = (fifo_level != '0) && (state == IDLE || state == RD_DRAIN);
  assign pop          = dev_wr_valid & dev_wr_ready;
  assign dev_rd_req   = (state == RD_REQ);

  always_ff @(posedge pxclk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (rd_tick) state_n = RD_DRAIN;
      RD_DRAIN: if (fifo_level == '0) state_n = RD_REQ;
      RD_REQ:   if (dev_rd_ack) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // During a read request the bus carries the read address instead of the FIFO head.
  always_comb begin
    dev_addr  = '0;
    dev_wdata = '0;
    if (fifo_level != '0) {dev_addr, dev_wdata} = mem[rd_ptr];
    if (state == RD_REQ) dev_addr = rd_addr;
  end

  assign err_set = (wr_tick & full) | (rd_tick & (state != IDLE));

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state    <= IDLE;
      rd_addr  <= '0;
      cpu_dout <= 8'h00;
      cpu_wait <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      if (state == IDLE && rd_tick) rd_addr <= cpu_addr;
      if (state == RD_REQ && dev_rd_ack) cpu_dout <= dev_rdata;
      cpu_wait <= (state != IDLE) || (fifo_level >= LW'(FIFO_DEPTH - 1));
      err      <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Bench for z80_bus_bridge: default instance plus a small-FIFO/short-sync/wide-address instance.
module tb_z80_bus_bridge;

  logic pxclk = 1'b0;
  logic reset = 1'b1;
  always #5 pxclk = ~pxclk;

  // default instance
  logic       c_addr = 1'b0, c_wr = 1'b0, c_rd = 1'b0;
  logic [7:0] c_din = 8'h00, c_dout, d_wdata, rdata = 8'h00;
  logic       c_wait, wr_vld, wr_rdy = 1'b0, d_addr, rd_req, rd_ack = 1'b0, err, err_clr = 1'b0;
  logic [2:0] level;

  // small instance
  logic [3:0] b_addr = 4'h0, b_daddr;
  logic [7:0] b_din = 8'h00, b_dout, b_wdata, b_rdata = 8'h00;
  logic       b_wr = 1'b0, b_rd = 1'b0, b_wait, b_vld, b_rdy = 1'b0, b_rdreq, b_ack = 1'b0, b_err, b_clr = 1'b0;
  logic [1:0] b_level;

  z80_bus_bridge u_dut (
    .pxclk(pxclk), .reset(reset), .cpu_addr(c_addr), .cpu_din(c_din), .cpu_wr(c_wr), .cpu_rd(c_rd),
    .cpu_dout(c_dout), .cpu_wait(c_wait), .dev_wr_valid(wr_vld), .dev_wr_ready(wr_rdy),
    .dev_addr(d_addr), .dev_wdata(d_wdata), .dev_rd_req(rd_req), .dev_rd_ack(rd_ack),
    .dev_rdata(rdata), .fifo_level(level), .err(err), .err_clr(err_clr)
  );

  z80_bus_bridge #(.ADDR_W(4), .SYN_LEN(2), .FIFO_DEPTH(2)) u_dut2 (
    .pxclk(pxclk), .reset(reset), .cpu_addr(b_addr), .cpu_din(b_din), .cpu_wr(b_wr), .cpu_rd(b_rd),
    .cpu_dout(b_dout), .cpu_wait(b_wait), .dev_wr_valid(b_vld), .dev_wr_ready(b_rdy),
    .dev_addr(b_daddr), .dev_wdata(b_wdata), .dev_rd_req(b_rdreq), .dev_rd_ack(b_ack),
    .dev_rdata(b_rdata), .fifo_level(b_level), .err(b_err), .err_clr(b_clr)
  );

  int checks = 0;
  int errors = 0;
  int vld_cycles = 0;
  int rd_rises = 0;
  logic rd_req_q = 1'b0;
  logic [8:0]  q1[$];
  logic [11:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pxclk);
  endtask

  // Scoreboard monitor: samples just after the negedge, once the stimulus for the next edge is settled.
  always begin
    @(negedge pxclk);
    #1;
    if (!reset) begin
      if (wr_vld) vld_cycles++;
      if (wr_vld && wr_rdy) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr1_unexpected: got addr=%0h data=%0h expected none", d_addr, d_wdata);
        end else check("wr1_order", {23'd0, d_addr, d_wdata}, {23'd0, q1.pop_front()});
      end
      if (b_vld && b_rdy) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr2_unexpected: got addr=%0h data=%0h expected none", b_daddr, b_wdata);
        end else check("wr2_order", {20'd0, b_daddr, b_wdata}, {20'd0, q2.pop_front()});
      end
    end
    if (rd_req && !rd_req_q) rd_rises++;
    rd_req_q = rd_req;
  end

  task automatic wr1(input logic a, input logic [7:0] d);
    c_addr = a; c_din = d; c_wr = 1'b1;
    cyc(6);
    c_wr = 1'b0;
    cyc(6);
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    b_addr = a; b_din = d; b_wr = 1'b1;
    cyc(5);
    b_wr = 1'b0;
    cyc(5);
  endtask

  task automatic rd1(input logic a);
    c_addr = a; c_rd = 1'b1;
    cyc(6);
    c_rd = 1'b0;
    cyc(2);
  endtask

  task automatic wait_rd_req(input int max, input string name);
    int k = 0;
    while (!rd_req && k < max) begin
      cyc(1);
      k++;
    end
    check(name, {31'd0, rd_req}, 32'd1);
  endtask

  task automatic ack1(input logic [7:0] d);
    rdata = d; rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
  endtask

  typedef struct {
    logic       a;
    logic [7:0] d;
    logic       rdy;
    logic       acc;
    logic [2:0] lvl;
    logic       wt;
    logic       er;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int first;
    int v0;
    int r0;
    tbl[0] = '{1'b1, 8'h5A, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'hFF, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h02, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h04, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};

    // reset values
    cyc(3);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_vld", {31'd0, wr_vld}, 32'd0);
    check("rst_rdreq", {31'd0, rd_req}, 32'd0);
    check("rst_dout", {24'd0, c_dout}, 32'd0);
    check("rst_wait", {31'd0, c_wait}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_bus", {23'd0, d_addr, d_wdata}, 32'd0);
    check("rst_level2", {30'd0, b_level}, 32'd0);
    reset = 1'b0;
    cyc(5);

    // write latency: valid first seen SYN_LEN+1 cycles after the cpu_wr rise, for exactly one cycle
    wr_rdy = 1'b1;
    q1.push_back({1'b1, 8'h5A});
    v0 = vld_cycles;
    first = 0;
    c_addr = 1'b1; c_din = 8'h5A; c_wr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge pxclk);
      if (wr_vld && first == 0) first = k;
    end
    c_wr = 1'b0;
    cyc(4);
    check("wr_latency", first, 32'd4);
    check("wr_vld_cycles", vld_cycles - v0, 32'd1);

    // table: passthrough writes, then fill with ready low until overflow
    for (int i = 0; i < 8; i++) begin
      wr_rdy = tbl[i].rdy;
      if (tbl[i].acc) q1.push_back({tbl[i].a, tbl[i].d});
      wr1(tbl[i].a, tbl[i].d);
      check("tbl_level", {29'd0, level}, {29'd0, tbl[i].lvl});
      check("tbl_wait", {31'd0, c_wait}, {31'd0, tbl[i].wt});
      check("tbl_err", {31'd0, err}, {31'd0, tbl[i].er});
    end

    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("err_clr", {31'd0, err}, 32'd0);

    // overflow while err_clr is held: set wins on the tick cycle, clear takes effect the next
    err_clr = 1'b1;
    c_addr = 1'b0; c_din = 8'h06; c_wr = 1'b1;
    cyc(4);
    check("set_wins", {31'd0, err}, 32'd1);
    cyc(1);
    check("clr_after", {31'd0, err}, 32'd0);
    err_clr = 1'b0;
    cyc(2);
    c_wr = 1'b0;
    cyc(4);
    check("full_level", {29'd0, level}, 32'd4);

    wr_rdy = 1'b1;
    cyc(10);
    check("drain_level", {29'd0, level}, 32'd0);
    check("drain_q", q1.size(), 32'd0);
    check("drain_wait", {31'd0, c_wait}, 32'd0);

    // read waits behind queued writes
    wr_rdy = 1'b0;
    q1.push_back({1'b1, 8'h11});
    wr1(1'b1, 8'h11);
    q1.push_back({1'b0, 8'h22});
    wr1(1'b0, 8'h22);
    rd1(1'b0);
    cyc(6);
    check("rd_blocked", {31'd0, rd_req}, 32'd0);
    check("rd_blk_level", {29'd0, level}, 32'd2);
    check("rd_blk_wait", {31'd0, c_wait}, 32'd1);
    wr_rdy = 1'b1;
    wait_rd_req(20, "rd_req_up");
    check("rd_after_drain", {29'd0, level}, 32'd0);
    check("rd_q_empty", q1.size(), 32'd0);
    check("rd_addr0", {31'd0, d_addr}, 32'd0);
    ack1(8'hC3);
    check("rd_req_drop", {31'd0, rd_req}, 32'd0);
    check("rd_dout", {24'd0, c_dout}, 32'hC3);
    cyc(2);
    check("rd_idle_wait", {31'd0, c_wait}, 32'd0);

    // second read during RD_REQ is ignored and flagged
    r0 = rd_rises;
    rd1(1'b1);
    wait_rd_req(20, "rd2_req_up");
    check("rd2_addr", {31'd0, d_addr}, 32'd1);
    cyc(3);
    rd1(1'b0);
    cyc(3);
    check("rd2_err", {31'd0, err}, 32'd1);
    check("rd2_still_req", {31'd0, rd_req}, 32'd1);
    ack1(8'h3C);
    check("rd2_dout", {24'd0, c_dout}, 32'h3C);
    cyc(20);
    check("rd2_single", rd_rises - r0, 32'd1);
    check("rd2_no_req", {31'd0, rd_req}, 32'd0);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    check("rd2_err_clr", {31'd0, err}, 32'd0);
    q1.push_back({1'b0, 8'h99});
    wr1(1'b0, 8'h99);
    check("dout_hold", {24'd0, c_dout}, 32'h3C);

    // reset during RD_REQ with cpu_rd held high
    c_addr = 1'b1; c_rd = 1'b1;
    wait_rd_req(20, "rd3_req_up");
    reset = 1'b1;
    cyc(2);
    check("mid_rst_dout", {24'd0, c_dout}, 32'd0);
    check("mid_rst_rdreq", {31'd0, rd_req}, 32'd0);
    check("mid_rst_vld", {31'd0, wr_vld}, 32'd0);
    check("mid_rst_wait", {31'd0, c_wait}, 32'd0);
    check("mid_rst_addr", {31'd0, d_addr}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    r0 = rd_rises;
    cyc(15);
    check("no_tick_held", rd_rises - r0, 32'd0);
    check("no_tick_wait", {31'd0, c_wait}, 32'd0);
    c_rd = 1'b0;
    cyc(5);
    c_addr = 1'b0; c_rd = 1'b1;
    wait_rd_req(20, "rd4_req_up");
    c_rd = 1'b0;
    ack1(8'h77);
    check("rd4_dout", {24'd0, c_dout}, 32'h77);

    // small instance: overflow at depth 2, then pointer wrap over 10 writes total
    b_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) q2.push_back({4'(k), 8'h10 + 8'(k)});
      wr2(4'(k), 8'h10 + 8'(k));
      check("b_fill_level", {30'd0, b_level}, (k < 2) ? k + 1 : 2);
    end
    check("b_ovf_err", {31'd0, b_err}, 32'd1);
    check("b_ovf_wait", {31'd0, b_wait}, 32'd1);
    b_clr = 1'b1; cyc(1); b_clr = 1'b0;
    check("b_err_clr", {31'd0, b_err}, 32'd0);
    b_rdy = 1'b1;
    cyc(8);
    check("b_drain0", {30'd0, b_level}, 32'd0);
    for (int p = 0; p < 4; p++) begin
      b_rdy = 1'b0;
      for (int j = 0; j < 2; j++) begin
        int k;
        k = 3 + 2 * p + j;
        if (k <= 9) begin
          q2.push_back({4'(k), 8'h10 + 8'(k)});
          wr2(4'(k), 8'h10 + 8'(k));
          check("b_pair_level", {30'd0, b_level}, j + 1);
        end
      end
      b_rdy = 1'b1;
      cyc(6);
      check("b_pair_drain", {30'd0, b_level}, 32'd0);
    end
    check("b_q_empty", q2.size(), 32'd0);
    check("b_final_err", {31'd0, b_err}, 32'd0);
    check("b_final_wait", {31'd0, b_wait}, 32'd0);
    check("q1_final", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/z80_bus_bridge.md
Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 1: width of the CPU register-select address (1 = legacy mode bit).
REQ-002 Parameter SYN_LEN, default 3, legal 2..8: number of synchroniser stages on cpu_wr and cpu_rd.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two, legal 2..64: number of entries in the posted-write FIFO.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named pxclk and reset.
REQ-005 pxclk  in  1  pixel clock, the only clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cpu_addr  in  ADDR_W  CPU register select; async, stable while a strobe is high.
REQ-008 cpu_din  in  8  CPU write data; async, stable while cpu_wr is high.
REQ-009 cpu_wr / cpu_rd  in  1 each  async active-high CPU strobes.
REQ-010 cpu_dout  out  8  registered read data held for the CPU.
REQ-011 cpu_wait  out  1  registered; high while the bridge cannot accept or complete a CPU access.
REQ-012 dev_wr_valid  out  1, dev_wr_ready  in  1  write handshake to the device.
REQ-013 dev_addr  out  ADDR_W, dev_wdata  out  8  write/read address and write data to the device.
REQ-014 dev_rd_req  out  1, dev_rd_ack  in  1, dev_rdata  in  8  read handshake from the device.
REQ-015 fifo_level  out  clog2(FIFO_DEPTH)+1  number of queued writes.
REQ-016 err  out  1  sticky; set on write overflow or a read strobe that arrives while busy.
REQ-017 err_clr  in  1  synchronous clear of err.

Function
REQ-018 Each strobe SHALL pass through a SYN_LEN-stage shift register; a tick SHALL be one pxclk pulse on the synchronised 0->1 edge.
REQ-019 cpu_addr and cpu_din SHALL be sampled by pxclk flops on the tick cycle only; no gated or derived clocks are permitted.
REQ-020 Write tick with FIFO not full: {addr,data} SHALL be pushed that cycle, and fifo_level SHALL increment on the next cycle.
REQ-021 Write tick with FIFO full: the write SHALL be dropped, err SHALL be set, and the FIFO SHALL be unchanged.
REQ-022 The FIFO head SHALL drive dev_addr/dev_wdata; dev_wr_valid = (level != 0) and (state == IDLE or state == RD_DRAIN).
REQ-023 A write SHALL transfer on a cycle with dev_wr_valid & dev_wr_ready, and the head SHALL pop that cycle; a push and a pop in the same cycle SHALL leave the level unchanged.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the full/empty distinction SHALL use the extra level bit.
REQ-025 FSM states: IDLE, RD_DRAIN, RD_REQ.
REQ-026 IDLE on read tick -> RD_DRAIN, with the read address captured.
REQ-027 RD_DRAIN -> RD_REQ on the first cycle the level is 0, including the cycle after the last pop.
REQ-028 In RD_REQ, dev_rd_req SHALL be held high and dev_addr SHALL equal the captured read address.
REQ-029 RD_REQ on dev_rd_ack: dev_rdata SHALL be latched into cpu_dout, dev_rd_req SHALL drop the next cycle, and the FSM SHALL go to IDLE.
REQ-030 Reads SHALL never overtake queued writes (strict program order).
REQ-031 A read tick outside IDLE SHALL be ignored and SHALL set err.
REQ-032 Simultaneous write and read ticks: the write SHALL be pushed first, and the read SHALL then drain it.
REQ-033 cpu_wait SHALL be high the cycle after any state != IDLE, or when the level >= FIFO_DEPTH-1.
REQ-034 cpu_dout SHALL hold its value until the next completed read.
REQ-035 err_clr and a concurrent set: set SHALL win.

Reset
REQ-036 Reset SHALL force: FIFO empty, fifo_level 0, FSM IDLE, cpu_dout 0x00, cpu_wait 0, dev_wr_valid 0, dev_rd_req 0, dev_addr 0, dev_wdata 0, err 0.
REQ-037 Synchroniser chains SHALL reset to all ones, so a strobe held high through reset produces no tick.
REQ-038 Reset mid-read or mid-write SHALL abandon the transaction with no further device handshake.

Verification
REQ-039 Defaults, write 0x5A to addr 1 with dev_wr_ready=1 -> one dev_wr_valid cycle with addr 1, data 0x5A, starting SYN_LEN+1 cycles after the cpu_wr rise.
REQ-040 dev_wr_ready=0, 5 writes 0x01..0x05 -> level 4, cpu_wait high at level 3, 5th dropped, err=1; ready=1 -> 0x01..0x04 emitted in order.
REQ-041 Queue 2 writes with ready=0, then read addr 0 -> dev_rd_req stays low until both writes transfer; ack with rdata 0xC3 -> cpu_dout=0xC3, FSM IDLE.
REQ-042 Second cpu_rd during RD_REQ -> ignored, err=1, a single dev_rd_req transaction; err_clr -> err=0.
REQ-043 Assert reset while in RD_REQ with cpu_rd held high -> all outputs at reset values, no tick after reset release until cpu_rd falls and rises again.
REQ-044 Repeat scenario 2 with FIFO_DEPTH=2, SYN_LEN=2, ADDR_W=4 -> pointer wrap over 10 writes with correct ordering and level.
